// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads, optional zero entry and a bulk-clear FSM.
// Define REGFILE_BYPASS_EN to forward an accepted write straight to same-address reads on that edge.
module reg_file_mp #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic                       wrt_en,
   input  logic [ADDR_W-1:0]          rd_i,
   input  logic [DATA_W-1:0]          dat_i,
   input  logic [NUM_RD*ADDR_W-1:0]   rs_i,
   output logic [NUM_RD*DATA_W-1:0]   rs_o,
   output logic                       rs_vld_o,
   input  logic                       clr_req_i,
   output logic                       busy_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ADDR_W-1:0]          r_ptr;
   logic [NUM_RD*DATA_W-1:0]   r_rs;
   logic                       r_vld;

   logic                       w_idle_en;
   logic                       w_clr_now;
   logic                       w_in_range;
   logic                       w_zero_hit;
   logic                       w_wr_ok;
   logic [DATA_W-1:0]          w_mem [DEPTH];
   logic [NUM_RD*DATA_W-1:0]   w_rd_data;

   assign w_idle_en  = clk_en && (r_state == IDLE);
   assign w_clr_now  = clk_en && (r_state == CLEAR);
   assign w_in_range = ({1'b0, rd_i} < DEPTH_EXT);
   assign w_zero_hit = (ZERO_REG != 0) && (rd_i == '0);
   // A write is only accepted in IDLE; during CLEAR it is dropped, not queued.
   assign w_wr_ok    = w_idle_en && wrt_en && w_in_range && !w_zero_hit;

   // Storage: each entry is cleared by the sweep pointer or loaded by an accepted write.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_q <= '0;
         end else if (w_clr_now && (r_ptr == IDX)) begin
            r_q <= '0;
         end else if (w_wr_ok && (rd_i == IDX)) begin
            r_q <= dat_i;
         end
      end

      assign w_mem[g] = r_q;
   end

   // Read mux: unmatched (out-of-range) and hardwired-zero addresses fall through to 0.
   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((rs_i[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
               w_rd_data[k*DATA_W +: DATA_W] = w_mem[i];
            end
         end
`ifdef REGFILE_BYPASS_EN
         if (w_wr_ok && (rs_i[k*ADDR_W +: ADDR_W] == rd_i)) begin
            w_rd_data[k*DATA_W +: DATA_W] = dat_i;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rs  <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= w_idle_en;
         if (w_idle_en) begin
            r_rs <= w_rd_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (clk_en && clr_req_i) w_state_nxt = CLEAR;
         CLEAR:   if (clk_en && (r_ptr == LAST_IDX)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pointer parks at 0 while idle so a new clear always starts from entry 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (clk_en) begin
         if ((r_state == IDLE) || (r_ptr == LAST_IDX)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   assign rs_o     = r_rs;
   assign rs_vld_o = r_vld;
   assign busy_o   = (r_state == CLEAR);

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the CPU datapath. It generalises the 8x8, two-read-port register bank to configurable width, depth and read-port count. It adds:
- a read-valid flag
- an optional hardwired-zero entry 0
- a sequential bulk-clear state machine

It sits between the decode stage (addresses) and the ALU operand inputs.

Parameters:
DATA_W, 8, bits per register
DEPTH, 8, number of registers (>=2)
ADDR_W, $clog2(DEPTH), address width
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
clk_en  in  1  clock enable; gates every synchronous update
wrt_en  in  1  write enable
rd_i  in  ADDR_W  write address
dat_i  in  DATA_W  write data
rs_i  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rs_o  out  NUM_RD*DATA_W  packed registered read data, port k at [k*DATA_W +: DATA_W]
rs_vld_o  out  1  rs_o holds data read on the previous enabled edge
clr_req_i  in  1  request bulk clear of all registers
busy_o  out  1  clear in progress

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0; rs_o = 0; rs_vld_o = 0; busy_o = 0
  - FSM = IDLE; clear pointer = 0
  - Reset takes effect regardless of clk or clk_en.
- clk_en=0: no state changes.
  - Memory, rs_o, FSM and pointer all hold.
  - rs_vld_o is forced to 0 on that edge.
- Write (IDLE, clk_en=1, wrt_en=1):
  - Mem[rd_i] <= dat_i.
  - Dropped if rd_i >= DEPTH, or if ZERO_REG=1 and rd_i=0.
- Read, 1-cycle latency:
  - On each clk_en edge in IDLE: rs_o[k] <= Mem[rs_i[k]]; rs_vld_o <= 1.
  - rs_i[k] >= DEPTH returns 0.
  - ZERO_REG=1 and rs_i[k]=0 returns 0.
  - Ports are independent; identical addresses on several ports are legal.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr_req_i=1 with clk_en=1. Pointer <= 0; busy_o <= 1.
  - CLEAR: on each clk_en edge, Mem[ptr] <= 0 and ptr <= ptr+1.
  - Leaving CLEAR: on the edge that clears ptr=DEPTH-1, go to IDLE and set busy_o <= 0. A clear therefore takes exactly DEPTH enabled cycles.
- During CLEAR:
  - wrt_en is ignored (write is lost, not queued)
  - rs_o holds; rs_vld_o = 0
  - clr_req_i is ignored
- clk_en=0 during CLEAR stalls the pointer.
- Simultaneous wrt_en and clr_req_i in IDLE: the write is performed on that edge and CLEAR starts from the next edge, so the written value ends up cleared.
- Simultaneous write and read of the same address: see Optional Feature.
- Reset asserted mid-clear: immediate return to IDLE with everything zeroed; a pending clear is not resumed.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read whose address equals rd_i on an edge where the write is accepted captures dat_i into rs_o on that same edge (write-through forwarding).
  - Forwarding is not applied when the write is dropped: out of range, ZERO_REG entry 0, or CLEAR.
- Undefined: such a read returns the old Mem contents; the new value is visible from the next read.

Test Plan:
1. Reset, then write 0xA5 to addr 3 and 0x3C to addr 5; next edge rs_i={3,5} -> rs_o={0xA5,0x3C}, rs_vld_o=1 one cycle later.
2. Write 0x77 to addr 2 with rs_i[0]=2 on the same edge -> rs_o[0]=0x77 with REGFILE_BYPASS_EN defined, the prior value (0xA5 if preloaded) without it; 0x77 either way on the next read.
3. ZERO_REG=1: write 0xFF to addr 0, read addr 0 -> 0x00; out-of-range address (DEPTH=6, addr 7) read -> 0x00 and its write has no effect.
4. Fill all 8 entries with 0x11, pulse clr_req_i -> busy_o=1 for exactly 8 enabled cycles; a write of 0x99 to addr 4 mid-clear is lost; after busy_o falls, all reads return 0x00.
5. clk_en toggled 0/1 during a clear -> busy_o duration equals 8 enabled edges; rs_vld_o=0 on every disabled edge.
6. Assert rst low mid-clear (ptr=3) and asynchronously between clock edges -> rs_o=0, busy_o=0, rs_vld_o=0 immediately; after release, reads of all addresses return 0x00 and the FSM is IDLE.
